// File: rtl/uart_wb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge_pkg
// Shared definitions for the UART-to-Wishbone bridge:
//   state_e      - bridge FSM states
//   rx_state_e   - UART receiver bit-timing states
//   CMD_WE_BIT   - command byte bit that selects write (1) or read (0)
//   TIMEOUT_DATA - response byte sent when a read is never acknowledged
//   cmd_valid()  - command byte format check (bits 6:4 must be zero)
// -----------------------------------------------------------------------------
package uart_wb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DATA,
      BUS,
      TX
   } state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   localparam int unsigned CMD_WE_BIT   = 7;
   localparam logic [7:0]  TIMEOUT_DATA = 8'hEE;

   function automatic logic cmd_valid(input logic [7:0] cmd);
      return cmd[6:4] == 3'b000;
   endfunction

endpackage

// File: rtl/uart_wb_bridge_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, with a 2-flop input synchroniser.
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset
//   rx_i        - raw UART line (asynchronous, idle high)
//   byte_o      - last received byte, valid while valid_o is high
//   valid_o     - one-cycle pulse at the stop-bit sample of a good frame
//   frame_err_o - one-cycle pulse at the stop-bit sample when stop is low
// -----------------------------------------------------------------------------
module uart_rx
   import uart_wb_bridge_pkg::*;
#(
   parameter int unsigned TICKS_PER_BIT = 417
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       valid_o,
   output logic       frame_err_o
);

   localparam logic [15:0] FULL_LAST = 16'(TICKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(TICKS_PER_BIT / 2 - 1);

   // Synchroniser and edge history reset high so reset release never looks
   // like a falling start edge.
   logic        sync1_q, sync2_q, prev_q;
   rx_state_e   state_q;
   logic [15:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         sync1_q     <= rx_i;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (prev_q && !sync2_q) begin
                  state_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (sync2_q) begin
                     state_q <= RX_IDLE;   // glitch, not a start bit
                  end else begin
                     state_q <= RX_DATA;
                     bit_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_LAST) begin
                  cnt_q   <= '0;
                  shift_q <= {sync2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_LAST) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
                  if (sync2_q) valid_o     <= 1'b1;
                  else         frame_err_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   assign byte_o = shift_q;

endmodule

// File: rtl/uart_wb_bridge.sv
// -----------------------------------------------------------------------------
// uart_wb_bridge
// UART command interface to a Wishbone B4 register bus.
// Command byte: bit7 = we, bits6:4 = 0, bits3:0 = adr. A write is followed by
// one data byte; a read returns one byte over UART (TIMEOUT_DATA if the slave
// never acknowledges).
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   uart_rx_i/uart_tx_o - UART lines, 8N1, idle high
//   wb_we_o, wb_adr_o, wb_dat_o, wb_stb_o - Wishbone master outputs
//   wb_dat_i, wb_ack_i  - Wishbone slave response
// -----------------------------------------------------------------------------
module uart_wb_bridge
   import uart_wb_bridge_pkg::*;
#(
   parameter int unsigned TICKS_PER_BIT = 417,
   parameter int unsigned ACK_TIMEOUT   = 255
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       uart_rx_i,
   output logic       uart_tx_o,
   output logic       wb_we_o,
   output logic [3:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   output logic       wb_stb_o,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_ack_i
);

   localparam int unsigned     TOW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [TOW-1:0]  TO_LAST  = TOW'(ACK_TIMEOUT - 1);
   localparam logic [15:0]     BIT_LAST = 16'(TICKS_PER_BIT - 1);

   logic [7:0] rx_byte;
   logic       rx_valid, rx_ferr, rx_ok;

   uart_rx #(.TICKS_PER_BIT(TICKS_PER_BIT)) u_rx (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rx_i        (uart_rx_i),
      .byte_o      (rx_byte),
      .valid_o     (rx_valid),
      .frame_err_o (rx_ferr)
   );

   assign rx_ok = rx_valid & ~rx_ferr;

   state_e         state_q;
   logic [TOW-1:0] to_q;
   logic [15:0]    tx_cnt_q;
   logic [3:0]     tx_bit_q;
   logic [7:0]     tx_shift_q;
   logic           tx_q, stb_q, we_q;
   logic [3:0]     adr_q;
   logic [7:0]     dat_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         to_q       <= '0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_ok && cmd_valid(rx_byte)) begin
                  adr_q <= rx_byte[3:0];
                  if (rx_byte[CMD_WE_BIT]) begin
                     state_q <= WAIT_DATA;
                  end else begin
                     state_q <= BUS;
                     we_q    <= 1'b0;
                     stb_q   <= 1'b1;
                     to_q    <= '0;
                  end
               end
            end
            WAIT_DATA: begin
               if (rx_ok) begin
                  state_q <= BUS;
                  dat_q   <= rx_byte;
                  we_q    <= 1'b1;
                  stb_q   <= 1'b1;
                  to_q    <= '0;
               end
            end
            // Strobe is raised on the edge that enters BUS so a data byte's
            // valid pulse is followed by strobe on the very next cycle.
            BUS: begin
               if (wb_ack_i || to_q == TO_LAST) begin
                  stb_q <= 1'b0;
                  to_q  <= '0;
                  if (we_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q    <= TX;
                     tx_q       <= 1'b0;   // start bit
                     tx_shift_q <= wb_ack_i ? wb_dat_i : TIMEOUT_DATA;
                     tx_bit_q   <= '0;
                     tx_cnt_q   <= '0;
                  end
               end else begin
                  to_q <= to_q + TOW'(1);
               end
            end
            // tx_bit_q: 0 = start, 1..8 = data, 9 = stop. The shifter fills
            // with ones so the stop level falls out after the eighth shift.
            TX: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 4'd9) begin
                     state_q <= IDLE;
                  end else begin
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= {1'b1, tx_shift_q[7:1]};
                     tx_bit_q   <= tx_bit_q + 4'd1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign uart_tx_o = tx_q;
   assign wb_stb_o  = stb_q;
   assign wb_we_o   = we_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;

endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 417: clk_i cycles per UART bit (48 MHz, 115200 baud); legal range 4..65535.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: maximum clk_i cycles a bus cycle waits for wb_ack_i.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 uart_rx_i  in  1  UART receive line, asynchronous to clk_i, idle high, 8N1, LSB first.
REQ-006 uart_tx_o  out  1  UART transmit line, idle high, 8N1, LSB first.
REQ-007 wb_we_o  out  1  Wishbone B4 write enable.
REQ-008 wb_adr_o  out  4  Wishbone register address.
REQ-009 wb_dat_o  out  8  Wishbone write data.
REQ-010 wb_stb_o  out  1  Wishbone strobe; also serves as cycle indication.
REQ-011 wb_dat_i  in  8  Wishbone read data, valid when wb_ack_i is high.
REQ-012 wb_ack_i  in  1  Wishbone acknowledge; may be combinational from wb_stb_o.

Function
REQ-013 uart_rx_i SHALL pass through a 2-flop synchroniser before any use.
REQ-014 RX SHALL detect a start bit on a synchronised high-to-low transition and re-sample at TICKS_PER_BIT/2.
REQ-015 RX SHALL treat a high line at that re-sample as a false start and return to idle.
REQ-016 RX SHALL sample each data bit and the stop bit at bit centre, spaced TICKS_PER_BIT cycles apart.
REQ-017 RX SHALL present each received byte as a one-cycle valid pulse, issued at the stop-bit sample.
REQ-018 RX SHALL drop a byte whose stop bit samples low (framing error); no valid pulse is issued.
REQ-019 Command byte format: bit7 = we, bits6:4 = 0, bits3:0 = adr.
REQ-020 A command byte with any of bits6:4 nonzero SHALL be discarded, and the FSM stays in IDLE.
REQ-021 FSM states SHALL be IDLE, WAIT_DATA, BUS, and TX.
REQ-022 IDLE + valid write command -> WAIT_DATA, latching adr.
REQ-023 IDLE + valid read command -> BUS, latching adr, with wb_we_o=0.
REQ-024 WAIT_DATA + next byte -> BUS, latching the byte into wb_dat_o, with wb_we_o=1.
REQ-025 BUS SHALL assert wb_stb_o from the cycle after entry until the cycle wb_ack_i is sampled high; wb_stb_o drops on the following edge.
REQ-026 wb_adr_o, wb_dat_o and wb_we_o SHALL be stable throughout a strobed cycle.
REQ-027 Write acked -> IDLE, with no UART response.
REQ-028 Read acked -> TX, with wb_dat_i captured in the ack cycle.
REQ-029 After ACK_TIMEOUT cycles without ack, the bridge SHALL deassert wb_stb_o. A write then goes to IDLE; a read goes to TX with response byte 0xEE.
REQ-030 TX SHALL send start bit, 8 data bits and stop bit, each TICKS_PER_BIT cycles, then return to IDLE.
REQ-031 RX bytes completing while in BUS or TX SHALL be discarded.
REQ-032 A write has one-cycle bus latency: stb rises 1 cycle after the data byte's valid pulse.
REQ-033 The first TX start-bit cycle SHALL begin 1 cycle after the read ack.

Reset
REQ-034 Asserting rst_ni SHALL immediately force: FSM to IDLE, RX and TX to idle, uart_tx_o=1, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, all counters to 0.
REQ-035 Reset mid-byte or mid-bus-cycle SHALL abandon the transaction with no bus or UART activity after release.
REQ-036 The synchroniser flops SHALL reset to 1, so no false start bit is produced after reset release.

Structure
REQ-037 The shared package SHALL hold: the FSM state enum, CMD_WE_BIT=7, and TIMEOUT_DATA=8'hEE.
REQ-038 The UART receiver SHALL be the single sub-module uart_rx (synchroniser, bit timing, byte/valid/frame-error outputs).
REQ-039 The TX shifter and FSM SHALL be inline in uart_wb_bridge.

Verification (TICKS_PER_BIT=4, ACK_TIMEOUT=8, slave = RGB LED peripheral with combinational ack)
REQ-040 Send 0x80, 0x5A -> one write, adr=0, dat=0x5A, wb_stb_o high exactly 1 cycle; red PWM register reads 0x5A; uart_tx_o stays high.
REQ-041 Send 0x02 to a slave model returning 0xC3 -> one read, adr=2; TX emits 0xC3 framed 8N1 with 4-cycle bits.
REQ-042 Send 0x05 with ack tied low -> wb_stb_o high 8 cycles then low; TX emits 0xEE.
REQ-043 Send 0x90 -> no bus cycle; a subsequent 0x81, 0x10 performs a write of adr=1, dat=0x10.
REQ-044 Send 0x80 with stop bit forced low, then 0x80, 0x33 -> the bad byte is ignored, and exactly one write of adr=0, dat=0x33 occurs.
REQ-045 Drop rst_ni in the middle of the 0x5A data byte -> outputs reach reset values asynchronously; after release, no bus cycle and uart_tx_o=1.
